wave_meter: RTL and testbench

WAVE_METER -- requirements
Module: wave_meter

---
 rtl/wave_meter_if.sv | 16 +
 rtl/wave_meter.sv | 82 ++++++++
 tb/tb_wave_meter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/wave_meter_if.sv
// wave_meter_if: sample stream in, acknowledge and measurement results out for wave_meter.
interface wave_meter_if #(
   parameter int PERIOD_W = 24
);
   logic                en, smp_valid, meas_ack, meas_valid, overrun, no_signal;
   logic [7:0]          smp, vmax, vmin;
   logic [PERIOD_W-1:0] period;
   modport master (
      output en, smp_valid, smp, meas_ack,
      input  period, vmax, vmin, meas_valid, overrun, no_signal
   );
   modport slave (
      input  en, smp_valid, smp, meas_ack,
      output period, vmax, vmin, meas_valid, overrun, no_signal
   );
endinterface

// File: rtl/wave_meter.sv
// wave_meter: hysteresis crossing detector measuring period and min/max of an 8-bit sample stream.
module wave_meter #(
   parameter logic [7:0] MID = 8'd128,
   parameter logic [7:0] HYST = 8'd8,
   parameter int PERIOD_W = 24
) (
   input logic         clk,
   input logic         rst,
   wave_meter_if.slave wm
);
   localparam logic [7:0] LO = MID - HYST;
   localparam logic [7:0] HI = MID + HYST;
   localparam logic [PERIOD_W-1:0] CNT_MAX = '1;
   typedef enum logic [1:0] {UNK, LOW, HIGH} cmp_t;
   typedef enum logic {WAIT_FIRST, MEASURING} phase_t;
   cmp_t                cmp_q, cmp_d;
   phase_t              phase_q;
   logic [PERIOD_W-1:0] cnt_q, period_q;
   logic [7:0]          max_q, min_q, max_d, min_d, vmax_q, vmin_q;
   logic                valid_q, overrun_q, nosig_q;
   logic                acc, is_lo, is_hi, rise, tmo;
   always_comb begin
      acc = wm.en && wm.smp_valid;
      is_lo = wm.smp <= LO;
      is_hi = wm.smp >= HI;
      cmp_d = !acc ? cmp_q : (is_hi && cmp_q != HIGH) ? HIGH : (is_lo && cmp_q != LOW) ? LOW : cmp_q;
      rise = acc && cmp_q == LOW && is_hi;
      tmo = phase_q == MEASURING && cnt_q == CNT_MAX;
      max_d = (acc && wm.smp > max_q) ? wm.smp : max_q;
      min_d = (acc && wm.smp < min_q) ? wm.smp : min_q;
   end
   // Timeout wins over a coincident edge: the count cannot represent that period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmp_q <= UNK;
         phase_q <= WAIT_FIRST;
         cnt_q <= '0;
         max_q <= 8'h00;
         min_q <= 8'hFF;
         period_q <= '0;
         vmax_q <= 8'h00;
         vmin_q <= 8'hFF;
         valid_q <= 1'b0;
         overrun_q <= 1'b0;
         nosig_q <= 1'b0;
      end else begin
         if (wm.meas_ack) valid_q <= 1'b0;
         if (!wm.en || tmo) begin
            cmp_q <= UNK;
            phase_q <= WAIT_FIRST;
            cnt_q <= '0;
            if (tmo) nosig_q <= 1'b1;
         end else begin
            cmp_q <= cmp_d;
            if (rise) begin
               cnt_q <= '0;
               max_q <= wm.smp;
               min_q <= wm.smp;
               phase_q <= MEASURING;
            end else if (phase_q == MEASURING) begin
               cnt_q <= cnt_q + 1'b1;
               max_q <= max_d;
               min_q <= min_d;
            end
            if (rise && phase_q == MEASURING) begin
               period_q <= cnt_q + 1'b1;
               vmax_q <= max_d;
               vmin_q <= min_d;
               valid_q <= 1'b1;
               overrun_q <= overrun_q | (valid_q & ~wm.meas_ack);
               nosig_q <= 1'b0;
            end
         end
      end
   end
   assign wm.period = period_q;
   assign wm.vmax = vmax_q;
   assign wm.vmin = vmin_q;
   assign wm.meas_valid = valid_q;
   assign wm.overrun = overrun_q;
   assign wm.no_signal = nosig_q;
endmodule

// File: tb/tb_wave_meter.sv
// tb_wave_meter: directed stimulus checked every cycle against an event-level model of the meter.
module tb_wave_meter;
   localparam int W = 9;
   localparam int LO = 120;
   localparam int HI = 136;
   logic clk = 1'b0;
   logic rst = 1'b1;
   wave_meter_if #(.PERIOD_W(W)) bus ();
   wave_meter #(.MID(8'd128), .HYST(8'd8), .PERIOD_W(W)) dut (.clk(clk), .rst(rst), .wm(bus));
   always #5 clk = ~clk;
   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int last_edge = 0;
   int m_cmp = 0;
   bit m_meas = 1'b0;
   bit m_rise, m_v0;
   int q[$];
   int e_period = 0, e_vmax = 0, e_vmin = 255;
   bit e_valid = 1'b0, e_ovr = 1'b0, e_nosig = 1'b0;
   task automatic chk(string name, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   // Model: cycle-stamped edges, sample list per period, hysteresis classification.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_meas = 1'b0;
         m_cmp = 0;
         e_period = 0;
         e_vmax = 0;
         e_vmin = 255;
         e_valid = 1'b0;
         e_ovr = 1'b0;
         e_nosig = 1'b0;
      end else begin
         cyc++;
         m_v0 = e_valid;
         if (bus.meas_ack) e_valid = 1'b0;
         if (!bus.en) begin
            m_meas = 1'b0;
            m_cmp = 0;
         end else if (m_meas && cyc - last_edge == (1 << W)) begin
            m_meas = 1'b0;
            m_cmp = 0;
            e_nosig = 1'b1;
         end else begin
            m_rise = 1'b0;
            if (bus.smp_valid) begin
               if (int'(bus.smp) >= HI && m_cmp != 2) begin
                  m_rise = (m_cmp == 1);
                  m_cmp = 2;
               end else if (int'(bus.smp) <= LO && m_cmp != 1) m_cmp = 1;
               if (m_meas) q.push_back(int'(bus.smp));
            end
            if (m_rise) begin
               if (m_meas) begin
                  e_period = cyc - last_edge;
                  e_vmax = 0;
                  e_vmin = 255;
                  foreach (q[i]) begin
                     if (q[i] > e_vmax) e_vmax = q[i];
                     if (q[i] < e_vmin) e_vmin = q[i];
                  end
                  if (m_v0 && !bus.meas_ack) e_ovr = 1'b1;
                  e_valid = 1'b1;
                  e_nosig = 1'b0;
               end
               m_meas = 1'b1;
               last_edge = cyc;
               q = {};
               q.push_back(int'(bus.smp));
            end
         end
      end
   end
   always @(negedge clk) begin
      chk("period", int'(bus.period), e_period);
      chk("vmax", int'(bus.vmax), e_vmax);
      chk("vmin", int'(bus.vmin), e_vmin);
      chk("meas_valid", int'(bus.meas_valid), int'(e_valid));
      chk("overrun", int'(bus.overrun), int'(e_ovr));
      chk("no_signal", int'(bus.no_signal), int'(e_nosig));
   end
   task automatic drive(bit e, bit v, int s, bit a);
      bus.en = e;
      bus.smp_valid = v;
      bus.smp = 8'(s);
      bus.meas_ack = a;
      @(negedge clk);
   endtask
   task automatic wave(int lo, int nlo, int hi, int nhi, bit a);
      for (int i = 0; i < nlo + nhi; i++) drive(1'b1, 1'b1, (i < nlo) ? lo : hi, a);
   endtask
   task automatic chk_reset(string tag);
      chk({tag, "_period"}, int'(bus.period), 0);
      chk({tag, "_vmax"}, int'(bus.vmax), 0);
      chk({tag, "_vmin"}, int'(bus.vmin), 255);
      chk({tag, "_valid"}, int'(bus.meas_valid), 0);
      chk({tag, "_overrun"}, int'(bus.overrun), 0);
      chk({tag, "_nosig"}, int'(bus.no_signal), 0);
   endtask
   initial begin
      drive(1'b0, 1'b0, 0, 1'b0);
      drive(1'b0, 1'b0, 0, 1'b0);
      chk_reset("rst0");
      rst = 1'b0;
      for (int r = 0; r < 3; r++) wave(0, 180, 255, 180, 1'b1);
      chk("sq_period", int'(bus.period), 360);
      chk("sq_vmax", int'(bus.vmax), 255);
      chk("sq_vmin", int'(bus.vmin), 0);
      drive(1'b0, 1'b0, 0, 1'b1);
      wave(0, 10, 255, 1, 1'b1);
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 0, 1'b1);
      for (int i = 0; i < 400; i++) drive(1'b1, 1'b1, (i % 2) ? 126 : 130, 1'b1);
      drive(1'b1, 1'b1, 255, 1'b1);
      chk("hyst_period", int'(bus.period), 411);
      chk("hyst_valid", int'(bus.meas_valid), 1);
      for (int i = 0; i < 520; i++) drive(1'b1, 1'b1, 200, 1'b1);
      chk("to_nosig", int'(bus.no_signal), 1);
      chk("to_period_hold", int'(bus.period), 411);
      wave(0, 1, 255, 1, 1'b1);
      chk("to_first_edge_nosig", int'(bus.no_signal), 1);
      wave(0, 50, 255, 1, 1'b1);
      chk("to_resume_period", int'(bus.period), 51);
      chk("to_resume_nosig", int'(bus.no_signal), 0);
      wave(0, 30, 255, 30, 1'b0);
      wave(0, 30, 255, 30, 1'b0);
      wave(10, 25, 180, 30, 1'b0);
      chk("ovr_period", int'(bus.period), 55);
      chk("ovr_vmax", int'(bus.vmax), 255);
      chk("ovr_vmin", int'(bus.vmin), 10);
      chk("ovr_flag", int'(bus.overrun), 1);
      for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 10, 1'b0);
      drive(1'b1, 1'b1, 180, 1'b1);
      chk("ackhit_period", int'(bus.period), 50);
      chk("ackhit_vmax", int'(bus.vmax), 180);
      chk("ackhit_valid", int'(bus.meas_valid), 1);
      chk("ackhit_overrun", int'(bus.overrun), 1);
      drive(1'b1, 1'b1, 180, 1'b1);
      chk("ack_clear", int'(bus.meas_valid), 0);
      wave(0, 10, 255, 1, 1'b0);
      for (int i = 0; i < 100; i++) drive(1'b1, 1'b1, 255, 1'b0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 chk_reset("arst");
      @(negedge clk);
      rst = 1'b0;
      wave(0, 10, 255, 1, 1'b0);
      chk("arst_first_edge", int'(bus.meas_valid), 0);
      wave(0, 40, 255, 1, 1'b0);
      chk("arst_period", int'(bus.period), 41);
      chk("arst_valid", int'(bus.meas_valid), 1);
      drive(1'b0, 1'b0, 0, 1'b1);
      for (int i = 0; i < 1080; i++) drive(1'b1, (i % 4) == 0, (((i / 4) % 90) < 45) ? 0 : 255, 1'b1);
      chk("sparse_period", int'(bus.period), 360);
      chk("sparse_vmax", int'(bus.vmax), 255);
      chk("sparse_vmin", int'(bus.vmin), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
